// File: rtl/mult_v3.sv
// mult_v3: colour-matrix stage for the de/hs/vs video stream.
//
// Each output channel j is
//   clip(((sum_i coe[j][i]*di[i]) + (off[j] << COE_FRAC) + half) >>> COE_FRAC)
// where the coefficients are signed fixed point, di is unsigned, and clip
// saturates to [0, 2^PIXEL_WIDTH-1]. The latency is a fixed 4 cycles.
//
// Coefficients, offsets and bypass are double-buffered. coe_wr_i loads the
// shadow set. A vs_i rising edge copies the shadow set into the active set,
// so a frame is always processed with one consistent set.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   coe_i               coefficient (j,i) at [(j*CH_COUNT+i)*COE_WIDTH +: COE_WIDTH]
//   off_i               offset j at [j*OFF_WIDTH +: OFF_WIDTH], integer pixel units
//   bypass_i            requested bypass mode
//   coe_wr_i            strobe that captures coe_i/off_i/bypass_i into the shadow set
//   di_i                input pixel, channel 0 in the LSBs
//   de_i, hs_i, vs_i    input video strobes
//   do_o                output pixel
//   de_o, hs_o, vs_o    strobes delayed to match do_o
//   sat_cnt_o           saturated channel samples in the last completed frame
module mult_v3 #(
  parameter int CH_COUNT    = 3,
  parameter int PIXEL_WIDTH = 8,
  parameter int COE_WIDTH   = 16,
  parameter int COE_FRAC    = 10,
  parameter int OFF_WIDTH   = 10
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [CH_COUNT*CH_COUNT*COE_WIDTH-1:0] coe_i,
  input  logic [CH_COUNT*OFF_WIDTH-1:0]          off_i,
  input  logic                                   bypass_i,
  input  logic                                   coe_wr_i,
  input  logic [CH_COUNT*PIXEL_WIDTH-1:0]        di_i,
  input  logic                                   de_i,
  input  logic                                   hs_i,
  input  logic                                   vs_i,
  output logic [CH_COUNT*PIXEL_WIDTH-1:0]        do_o,
  output logic                                   de_o,
  output logic                                   hs_o,
  output logic                                   vs_o,
  output logic [31:0]                            sat_cnt_o
);

  localparam int CW     = CH_COUNT * CH_COUNT * COE_WIDTH;
  localparam int OW     = CH_COUNT * OFF_WIDTH;
  localparam int DW     = CH_COUNT * PIXEL_WIDTH;
  localparam int PROD_W = PIXEL_WIDTH + 1 + COE_WIDTH;
  localparam int ACC_W  = PIXEL_WIDTH + COE_WIDTH + 1 + $clog2(CH_COUNT);
  localparam int RES_W  = ACC_W - COE_FRAC;
  localparam int INC_W  = $clog2(CH_COUNT + 1);

  localparam logic signed [ACC_W-1:0] RND_C   = ACC_W'(1 << (COE_FRAC - 1));
  localparam logic signed [RES_W-1:0] PIX_MAX = RES_W'((1 << PIXEL_WIDTH) - 1);

  function automatic logic [CW-1:0] identity_coe();
    logic [CW-1:0] r;
    r = '0;
    for (int j = 0; j < CH_COUNT; j++)
      r[(j*CH_COUNT+j)*COE_WIDTH +: COE_WIDTH] = COE_WIDTH'(1 << COE_FRAC);
    return r;
  endfunction

  localparam logic [CW-1:0] COE_ID = identity_coe();

  // Coefficient sets
  logic [CW-1:0] coe_sh_q, coe_act_q;
  logic [OW-1:0] off_sh_q, off_act_q;
  logic          byp_sh_q, byp_act_q;
  logic          vs_in_q;
  logic          vs_rise;

  // vs_in_q resets to 1 so that a vs_i still high after a mid-frame reset is
  // not mistaken for the start of a new frame.
  assign vs_rise = vs_i & ~vs_in_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      coe_sh_q  <= COE_ID;
      off_sh_q  <= '0;
      byp_sh_q  <= 1'b0;
      coe_act_q <= COE_ID;
      off_act_q <= '0;
      byp_act_q <= 1'b0;
      vs_in_q   <= 1'b1;
    end else begin
      // The active set always takes the shadow value from before this edge,
      // so a coincident write only lands in the shadow.
      if (vs_rise) begin
        coe_act_q <= coe_sh_q;
        off_act_q <= off_sh_q;
        byp_act_q <= byp_sh_q;
      end
      if (coe_wr_i) begin
        coe_sh_q <= coe_i;
        off_sh_q <= off_i;
        byp_sh_q <= bypass_i;
      end
      vs_in_q <= vs_i;
    end
  end

  // Datapath
  logic signed [PROD_W-1:0] prod_d  [CH_COUNT*CH_COUNT];
  logic signed [PROD_W-1:0] prod_q  [CH_COUNT*CH_COUNT];
  logic signed [ACC_W-1:0]  sum_d   [CH_COUNT];
  logic signed [ACC_W-1:0]  sum_q   [CH_COUNT];
  logic signed [ACC_W-1:0]  rnd_acc [CH_COUNT];
  logic signed [RES_W-1:0]  res_d   [CH_COUNT];
  logic signed [RES_W-1:0]  res_q   [CH_COUNT];
  logic [DW-1:0]            do_d, do_q;
  logic [CH_COUNT-1:0]      sat_d, sat_q;
  logic [DW-1:0]            di1_q, di2_q, di3_q;
  logic                     byp1_q, byp2_q, byp3_q;
  logic [3:0]               de_sr_q, hs_sr_q, vs_sr_q;

  // S1: products, di zero-extended to a non-negative signed operand
  always_comb begin
    for (int j = 0; j < CH_COUNT; j++)
      for (int i = 0; i < CH_COUNT; i++)
        prod_d[j*CH_COUNT+i] =
          PROD_W'($signed(coe_act_q[(j*CH_COUNT+i)*COE_WIDTH +: COE_WIDTH])) *
          PROD_W'($signed({1'b0, di_i[i*PIXEL_WIDTH +: PIXEL_WIDTH]}));
  end

  // S2: channel sum
  always_comb begin
    for (int j = 0; j < CH_COUNT; j++) begin
      sum_d[j] = '0;
      for (int i = 0; i < CH_COUNT; i++)
        sum_d[j] = sum_d[j] + ACC_W'(prod_q[j*CH_COUNT+i]);
    end
  end

  // S3: offset, round half-up, drop fractional bits
  always_comb begin
    for (int j = 0; j < CH_COUNT; j++) begin
      rnd_acc[j] = sum_q[j]
                 + (ACC_W'($signed(off_act_q[j*OFF_WIDTH +: OFF_WIDTH])) <<< COE_FRAC)
                 + RND_C;
      res_d[j]   = RES_W'(rnd_acc[j] >>> COE_FRAC);
    end
  end

  // S4: saturation; flags only count for valid pixels (stage-3 de)
  always_comb begin
    do_d  = '0;
    sat_d = '0;
    for (int j = 0; j < CH_COUNT; j++) begin
      if (res_q[j][RES_W-1]) begin
        do_d[j*PIXEL_WIDTH +: PIXEL_WIDTH] = '0;
        sat_d[j] = de_sr_q[2];
      end else if (res_q[j] > PIX_MAX) begin
        do_d[j*PIXEL_WIDTH +: PIXEL_WIDTH] = '1;
        sat_d[j] = de_sr_q[2];
      end else begin
        do_d[j*PIXEL_WIDTH +: PIXEL_WIDTH] = res_q[j][PIXEL_WIDTH-1:0];
      end
    end
    if (byp3_q) begin
      do_d  = di3_q;
      sat_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CH_COUNT*CH_COUNT; k++) prod_q[k] <= '0;
      for (int j = 0; j < CH_COUNT; j++) begin
        sum_q[j] <= '0;
        res_q[j] <= '0;
      end
      di1_q   <= '0;
      di2_q   <= '0;
      di3_q   <= '0;
      byp1_q  <= 1'b0;
      byp2_q  <= 1'b0;
      byp3_q  <= 1'b0;
      do_q    <= '0;
      sat_q   <= '0;
      de_sr_q <= 4'b0000;
      hs_sr_q <= 4'b1111;
      vs_sr_q <= 4'b0000;
    end else begin
      prod_q  <= prod_d;
      sum_q   <= sum_d;
      res_q   <= res_d;
      di1_q   <= di_i;
      di2_q   <= di1_q;
      di3_q   <= di2_q;
      byp1_q  <= byp_act_q;
      byp2_q  <= byp1_q;
      byp3_q  <= byp2_q;
      do_q    <= do_d;
      sat_q   <= sat_d;
      de_sr_q <= {de_sr_q[2:0], de_i};
      hs_sr_q <= {hs_sr_q[2:0], hs_i};
      vs_sr_q <= {vs_sr_q[2:0], vs_i};
    end
  end

  // Saturation counter
  logic [INC_W-1:0] inc;
  logic [32:0]      cnt_sum;
  logic [31:0]      cnt_d, cnt_q, sat_cnt_q;
  logic             capture;
  logic             frame_ok_q;

  always_comb begin
    inc = '0;
    for (int j = 0; j < CH_COUNT; j++)
      inc = inc + INC_W'(sat_q[j] & de_sr_q[3]);
    cnt_sum = {1'b0, cnt_q} + 33'(inc);
    cnt_d   = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
  end

  // vs_o is about to fall: the current output cycle is the last of the frame.
  assign capture = vs_sr_q[3] & ~vs_sr_q[2];

  // frame_ok_q marks a frame that began with a real vs_i rise, so a frame
  // cut short by reset never publishes a count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      sat_cnt_q  <= '0;
      frame_ok_q <= 1'b0;
    end else if (capture) begin
      cnt_q      <= '0;
      if (frame_ok_q) sat_cnt_q <= cnt_d;
      frame_ok_q <= vs_rise;
    end else begin
      cnt_q      <= cnt_d;
      if (vs_rise) frame_ok_q <= 1'b1;
    end
  end

  assign do_o      = do_q;
  assign de_o      = de_sr_q[3];
  assign hs_o      = hs_sr_q[3];
  assign vs_o      = vs_sr_q[3];
  assign sat_cnt_o = sat_cnt_q;

endmodule

// File: tb/tb_mult_v3.sv
// tb_mult_v3: directed bench for mult_v3. Every driven cycle pushes the
// expected output word into exp_q; it is checked four cycles later.
module tb_mult_v3;

  localparam int CH = 3;
  localparam int PW = 8;
  localparam int CW = 16;
  localparam int OW = 10;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [CH*CH*CW-1:0] coe_i = '0;
  logic [CH*OW-1:0]    off_i = '0;
  logic                bypass_i = 1'b0;
  logic                coe_wr_i = 1'b0;
  logic [CH*PW-1:0]    di_i = '0;
  logic                de_i = 1'b0;
  logic                hs_i = 1'b1;
  logic                vs_i = 1'b0;
  logic [CH*PW-1:0]    do_o;
  logic                de_o, hs_o, vs_o;
  logic [31:0]         sat_cnt_o;

  mult_v3 #(
    .CH_COUNT(CH), .PIXEL_WIDTH(PW), .COE_WIDTH(CW), .COE_FRAC(10), .OFF_WIDTH(OW)
  ) dut (
    .clk(clk), .rst(rst), .coe_i(coe_i), .off_i(off_i), .bypass_i(bypass_i),
    .coe_wr_i(coe_wr_i), .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .sat_cnt_o(sat_cnt_o)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard: {check_do, do, de, hs, vs}
  logic [27:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        wr_next  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [CH*CH*CW-1:0] diag(input logic [CW-1:0] d);
    logic [CH*CH*CW-1:0] r;
    r = '0;
    for (int j = 0; j < CH; j++) r[(j*CH+j)*CW +: CW] = d;
    return r;
  endfunction

  // Driver: one cycle. Compares the entry queued four cycles ago, then
  // drives this cycle's inputs and queues what they should produce.
  task automatic step(input logic [23:0] di, input logic de, input logic hs,
                      input logic vs, input logic [23:0] exp_do, input logic do_rst);
    logic [27:0] e;
    @(negedge clk);
    if (exp_q.size() >= 4) begin
      e = exp_q.pop_front();
      if (e[27]) check("do", {8'h0, do_o}, {8'h0, e[26:3]});
      check("de", {31'h0, de_o}, {31'h0, e[2]});
      check("hs", {31'h0, hs_o}, {31'h0, e[1]});
      check("vs", {31'h0, vs_o}, {31'h0, e[0]});
    end
    rst      = do_rst;
    di_i     = di;
    de_i     = de;
    hs_i     = hs;
    vs_i     = vs;
    coe_wr_i = wr_next;
    wr_next  = 1'b0;
    if (do_rst) begin
      exp_q.delete();
      repeat (4) exp_q.push_back({1'b1, 24'h0, 1'b0, 1'b1, 1'b0});
    end else begin
      exp_q.push_back({de, exp_do, de, hs, vs});
    end
  endtask

  task automatic idle(input int n, input logic vs);
    repeat (n) step(24'h0, 1'b0, 1'b1, vs, 24'h0, 1'b0);
  endtask

  // Queue a shadow write; it is strobed on the next step.
  task automatic write_cfg(input logic [CH*CH*CW-1:0] c, input logic [CH*OW-1:0] o,
                           input logic byp);
    coe_i    = c;
    off_i    = o;
    bypass_i = byp;
    wr_next  = 1'b1;
  endtask

  task automatic vs_start();
    idle(2, 1'b1);
  endtask

  task automatic vs_end();
    idle(2, 1'b0);
  endtask

  // One line: n pixels, gap idle de=0 cycles after each, then 2 blanking cycles.
  task automatic line(input int n, input int gap, input logic [23:0] di,
                      input logic [23:0] exp_do);
    for (int k = 0; k < n; k++) begin
      step(di, 1'b1, 1'b0, 1'b1, exp_do, 1'b0);
      repeat (gap) step(di, 1'b0, 1'b0, 1'b1, exp_do, 1'b0);
    end
    idle(2, 1'b1);
  endtask

  task automatic frame(input int lines, input int n, input int gap,
                       input logic [23:0] di, input logic [23:0] exp_do);
    vs_start();
    repeat (lines) line(n, gap, di, exp_do);
    vs_end();
    idle(6, 1'b0);
  endtask

  logic [CH*CH*CW-1:0] rnd_coe;
  logic [CH*PW-1:0]    rnd_di;

  initial begin
    // Reset
    step(24'h0, 1'b0, 1'b1, 1'b0, 24'h0, 1'b1);
    idle(4, 1'b0);
    check("sat_cnt_reset", sat_cnt_o, 32'd0);

    // Identity after reset, DE period 2
    frame(2, 4, 1, 24'h302010, 24'h302010);
    check("sat_cnt_identity", sat_cnt_o, 32'd0);

    // Rounding: 0.5 * 3 = 1.5 -> 2, 0.5 * 2 = 1.0 -> 1
    write_cfg(diag(16'd512), '0, 1'b0);
    idle(1, 1'b0);
    vs_start();
    line(3, 0, 24'h030303, 24'h020202);
    line(3, 0, 24'h020202, 24'h010101);
    vs_end();
    idle(6, 1'b0);
    check("sat_cnt_round", sat_cnt_o, 32'd0);

    // Cross terms and offset: ch0 = 100 + 50 - 10 = 140; 3 + 2 - 10 clips to 0
    rnd_coe = diag(16'd1024);
    rnd_coe[1*CW +: CW] = 16'd1024;
    write_cfg(rnd_coe, {10'h0, 10'h0, 10'h3F6}, 1'b0);
    idle(1, 1'b0);
    vs_start();
    line(4, 0, 24'h003264, 24'h00328C);
    line(2, 0, 24'h000203, 24'h000200);
    vs_end();
    idle(6, 1'b0);
    check("sat_cnt_cross", sat_cnt_o, 32'd2);

    // Frame-boundary update
    write_cfg(diag(16'd1024), '0, 1'b0);
    idle(1, 1'b0);
    frame(1, 3, 0, 24'h102030, 24'h102030);
    vs_start();
    line(3, 0, 24'h102030, 24'h102030);
    write_cfg(diag(16'd2048), '0, 1'b0);
    idle(1, 1'b1);
    line(3, 0, 24'h102030, 24'h102030);
    vs_end();
    idle(4, 1'b0);
    // write coincident with the vs rise: this frame still uses the doubling set
    write_cfg(diag(16'd1024), '0, 1'b0);
    frame(2, 3, 0, 24'h102030, 24'h204060);
    frame(1, 3, 0, 24'h102030, 24'h102030);

    // Saturation high and low, with the frame counter
    write_cfg(diag(16'd2048), '0, 1'b0);
    idle(1, 1'b0);
    frame(10, 20, 0, 24'hC8C8C8, 24'hFFFFFF);
    check("sat_cnt_high", sat_cnt_o, 32'd600);
    write_cfg(diag(16'hFC00), '0, 1'b0);
    idle(1, 1'b0);
    frame(2, 5, 0, 24'hC8C8C8, 24'h000000);
    check("sat_cnt_low", sat_cnt_o, 32'd30);

    // Bypass with random coefficients and offsets
    for (int k = 0; k < CH*CH; k++) rnd_coe[k*CW +: CW] = CW'($urandom_range(0, 65535));
    write_cfg(rnd_coe, 30'($urandom), 1'b1);
    idle(1, 1'b0);
    vs_start();
    for (int l = 0; l < 2; l++) begin
      for (int k = 0; k < 6; k++) begin
        rnd_di = 24'($urandom);
        step(rnd_di, 1'b1, 1'b0, 1'b1, rnd_di, 1'b0);
      end
      idle(2, 1'b1);
    end
    vs_end();
    idle(6, 1'b0);
    check("sat_cnt_bypass", sat_cnt_o, 32'd0);

    // Saturating frame, then reset mid-line in the following frame
    write_cfg(diag(16'd2048), '0, 1'b0);
    idle(1, 1'b0);
    frame(1, 4, 0, 24'hC8C8C8, 24'hFFFFFF);
    check("sat_cnt_pre_reset", sat_cnt_o, 32'd12);
    vs_start();
    repeat (3) step(24'hC8C8C8, 1'b1, 1'b0, 1'b1, 24'hFFFFFF, 1'b0);
    step(24'hC8C8C8, 1'b1, 1'b0, 1'b1, 24'h0, 1'b1);
    step(24'h102030, 1'b1, 1'b0, 1'b1, 24'h102030, 1'b0);
    check("sat_cnt_after_reset", sat_cnt_o, 32'd0);
    repeat (3) step(24'h102030, 1'b1, 1'b0, 1'b1, 24'h102030, 1'b0);
    idle(2, 1'b1);
    vs_end();
    idle(6, 1'b0);
    check("sat_cnt_partial", sat_cnt_o, 32'd0);

    // Identity restored in a full frame after reset
    frame(1, 3, 0, 24'h102030, 24'h102030);
    check("sat_cnt_final", sat_cnt_o, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mult_v3.md
# mult_v3

Parametrised colour-matrix stage for the video filter chain, successor to the three-coefficient multiplier. Each output channel is a full signed weighted sum of all input channels plus a per-channel offset, then rounded and saturated. Coefficients and offsets are double-buffered so that updates apply only at frame boundaries. A per-frame saturation counter is included. The block sits between the pixel source and downstream filters/monitor on the de/hs/vs video stream.

## Interface
- CH_COUNT, 3: number of colour channels in and out.
- PIXEL_WIDTH, 8: unsigned bits per channel.
- COE_WIDTH, 16: signed coefficient width.
- COE_FRAC, 10: fractional bits of a coefficient; `1<<COE_FRAC` is 1.000.
- OFF_WIDTH, 10: signed offset width, integer pixel units.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- coe_i  in  CH_COUNT*CH_COUNT*COE_WIDTH  coefficient for output j, input i at `[(j*CH_COUNT+i)*COE_WIDTH +: COE_WIDTH]`.
- off_i  in  CH_COUNT*OFF_WIDTH  offset for output j at `[j*OFF_WIDTH +: OFF_WIDTH]`.
- bypass_i  in  1  requested bypass mode.
- coe_wr_i  in  1  one-cycle strobe that captures coe_i, off_i and bypass_i into the shadow set.
- di_i  in  CH_COUNT*PIXEL_WIDTH  input pixel; channel 0 is in the LSBs.
- de_i, hs_i, vs_i  in  1 each  video strobes. de is high on valid pixels; vs is high during the frame; hs is high during line blanking.
- do_o  out  CH_COUNT*PIXEL_WIDTH  output pixel.
- de_o, hs_o, vs_o  out  1 each  input strobes delayed to match do_o.
- sat_cnt_o  out  32  number of saturated channel samples in the last completed frame.

## Operation
- Shadow set: loaded from coe_i, off_i and bypass_i on any cycle with coe_wr_i=1.
- Active set: loaded from the shadow set on a vs_i rising edge (vs_i=1 while registered vs_i was 0).
- No path exists from coe_i into the active set other than through this frame-boundary load.
- If coe_wr_i and the vs_i rising edge occur in the same cycle, the active set takes the old shadow and the new write lands in the shadow only.
- Reset values for both sets:
  - Coefficients: identity. Diagonal is `1<<COE_FRAC`; all other entries are 0.
  - Offsets: 0.
  - bypass: 0.
- Datapath per output j: `acc = sum_i coe[j][i]*di[i]`.
  - Products are signed; di is zero-extended.
  - acc width is PIXEL_WIDTH+COE_WIDTH+1+clog2(CH_COUNT). acc never overflows.
  - Offset: `acc += off[j] << COE_FRAC`.
  - Round half-up: `acc += 1<<(COE_FRAC-1)`, then arithmetic shift right by COE_FRAC.
  - Saturate: results below 0 become 0; results above 2^PIXEL_WIDTH-1 become 2^PIXEL_WIDTH-1. Each clipped channel with de=1 raises that channel's sat flag.
- Bypass (active set): do_o equals di_i delayed by the same latency. Saturation flags are forced to 0.
- The datapath computes on every cycle regardless of de_i. Downstream logic qualifies data with de_o.
- Saturation counter:
  - The internal counter adds the number of set sat flags (0..CH_COUNT) on each output cycle with de=1.
  - On the falling edge of the pipelined vs, sat_cnt_o takes the internal value plus the current cycle's increment, and the internal counter clears to 0.
  - The internal counter saturates at 2^32-1; it does not wrap.

## Timing
- Fixed latency of 4 cycles from di_i/de_i/hs_i/vs_i to do_o/de_o/hs_o/vs_o. Pipeline stages:
  - S1: input register and products.
  - S2: channel sum.
  - S3: offset and rounding.
  - S4: saturation and output register.
- Strobes are delayed through a 4-deep shift register. Strobe relationships are preserved exactly at any de duty cycle, including continuous de=1 and gapped de.
- The active set changes on the cycle after the vs_i rise. The first pixel of the frame therefore uses the new set, since de_i is never high in the same cycle as the vs_i rise.
- Reset values, held the cycle after rst=1:
  - do_o = 0, de_o = 0, vs_o = 0, hs_o = 1.
  - sat_cnt_o = 0; internal counter = 0.
  - Pipeline contents are flushed.
  - Shadow and active sets return to identity.
- Reset mid-frame: outputs return to the reset values immediately. The next valid data appears 4 cycles after de_i resumes. The partial frame never updates sat_cnt_o.

## Test plan
- Identity after reset. Input di_i=0x302010 with de_i pulses, DE period 2. Expected: do_o=0x302010 exactly 4 cycles later; de_o/hs_o/vs_o match the input strobes delayed by 4; sat_cnt_o stays 0 after the frame.
- Rounding. Diagonal=512 (0.5), off=0, di channel value 3. Expected: output 2 (1.5 rounds up). With di=2, expected output 1.
- Saturation and counter. Diagonal=2048 (2.0), di=200 on all 3 channels, 600x600 frame. Expected: do_o=0xFFFFFF and sat_cnt_o=1,080,000 after vs falls. Diagonal=-1024, off=0: expected do_o=0.
- Cross terms and offset. Row 0 = {1024, 1024, 0}, off[0]=-10, di={ch0=100, ch1=50}. Expected: output ch0=140.
- Frame-boundary update. Pulse coe_wr_i with diagonal 2048 at mid-frame. Expected: the remaining pixels of the frame stay identity; pixels of the next frame are doubled. Also check coe_wr_i coincident with the vs_i rise: the old shadow is applied.
- Bypass and reset. Random coefficients with bypass=1. Expected: do_o equals di_i delayed by 4. Then assert rst for 1 cycle mid-line. Expected: do_o=0, de_o=0, hs_o=1 next cycle; identity restored; sat_cnt_o=0.
